muldiv_sequencer: RTL and testbench

Iterative signed multiply/divide unit with its own sequencing FSM for the 32-bit datapath's MUL/DIV instructions. Accepts one operation through a valid/ready handshake. Runs radix-2 Booth multiplication or non-restoring division over one shared adder/shift register. Returns the 2*WORD result split into HI/LO with a one-cycle done pulse.

---
 rtl/muldiv_sequencer_if.sv | 38 +++
 rtl/muldiv_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Handshake and result bundle for muldiv_sequencer.
//
//   start_valid  requester -> unit  request present
//   start_ready  unit -> requester  unit can accept (IDLE only)
//   op           requester -> unit  0 = signed MUL, 1 = signed DIV
//   src_a        requester -> unit  multiplicand / dividend
//   src_b        requester -> unit  multiplier / divisor
//   abort        requester -> unit  cancel the operation in flight
//   busy         unit -> requester  operation in progress
//   done         unit -> requester  one-cycle result strobe
//   hi_out       unit -> requester  MUL high product word / DIV remainder
//   lo_out       unit -> requester  MUL low product word / DIV quotient
//   div_by_zero  unit -> requester  DIV with zero divisor, valid with done
interface muldiv_sequencer_if #(
    parameter int WORD = 32
);
    logic            start_valid;
    logic            start_ready;
    logic            op;
    logic [WORD-1:0] src_a;
    logic [WORD-1:0] src_b;
    logic            abort;
    logic            busy;
    logic            done;
    logic [WORD-1:0] hi_out;
    logic [WORD-1:0] lo_out;
    logic            div_by_zero;

    modport master (
        output start_valid, op, src_a, src_b, abort,
        input  start_ready, busy, done, hi_out, lo_out, div_by_zero
    );

    modport slave (
        input  start_valid, op, src_a, src_b, abort,
        output start_ready, busy, done, hi_out, lo_out, div_by_zero
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply/divide unit with its own sequencing FSM.
// MUL uses Booth recoding, DIV uses non-restoring division on operand
// magnitudes; both share one accumulator, one adder and one shift register.
// Results: MUL -> {hi_out, lo_out} = product; DIV -> hi_out = remainder
// (sign of dividend), lo_out = quotient (truncating).
//
// Ports:
//   clk  rising-edge clock
//   clr  asynchronous active-low reset
//   bus  muldiv_sequencer_if.slave (handshake, operands, abort, results)
//
// Build option: define MULDIV_RADIX4_EN to run MUL with radix-4 Booth
// (WORD/2 iterations instead of WORD). DIV and all results are unchanged.
module muldiv_sequencer #(
    parameter int WORD = 32
) (
    input logic               clk,
    input logic               clr,
    muldiv_sequencer_if.slave bus
);

`ifdef MULDIV_RADIX4_EN
    localparam int ACC_W     = WORD + 2;
    localparam int MUL_STEPS = WORD / 2;
`else
    localparam int ACC_W     = WORD + 1;
    localparam int MUL_STEPS = WORD;
`endif
    localparam int CNT_W = $clog2(WORD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ITER,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    // operands captured at accept
    logic            op_r;
    logic [WORD-1:0] a_r;
    logic [WORD-1:0] b_r;

    // shared datapath: acc = Booth A / partial remainder, m = M / divisor,
    // q = multiplier-product low / dividend-quotient
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] m;
    logic [WORD-1:0]         q;
    logic                    q_1;
    logic                    neg_q;
    logic                    neg_r;
    logic [CNT_W-1:0]        cnt;

    logic signed [ACC_W-1:0] add_l, add_r, sum;
    logic signed [ACC_W-1:0] acc_step;
    logic [WORD-1:0]         q_step;
    logic                    q1_step;
    logic [WORD-1:0]         res_hi, res_lo;

    logic [WORD-1:0] hi_r, lo_r;
    logic            dbz_r;

    function automatic logic [WORD-1:0] cond_neg(input logic [WORD-1:0] v,
                                                 input logic neg);
        return neg ? (~v + WORD'(1)) : v;
    endfunction

    // |v| as unsigned; the most negative value maps to 2^(WORD-1)
    function automatic logic [WORD-1:0] mag(input logic [WORD-1:0] v);
        return cond_neg(v, v[WORD-1]);
    endfunction

`ifdef MULDIV_RADIX4_EN
    function automatic logic signed [ACC_W-1:0] booth_addend(
        input logic [2:0] sel, input logic signed [ACC_W-1:0] mv);
        case (sel)
            3'b001, 3'b010: return mv;
            3'b011:         return mv <<< 1;
            3'b100:         return -(mv <<< 1);
            3'b101, 3'b110: return -mv;
            default:        return '0;
        endcase
    endfunction
`else
    function automatic logic signed [ACC_W-1:0] booth_addend(
        input logic [1:0] sel, input logic signed [ACC_W-1:0] mv);
        case (sel)
            2'b10:   return -mv;
            2'b01:   return mv;
            default: return '0;
        endcase
    endfunction
`endif

    // ---- next-state logic ----
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start_valid) state_nxt = S_INIT;
            S_INIT: begin
                if (bus.abort)                 state_nxt = S_IDLE;
                else if (op_r && (b_r == '0))  state_nxt = S_DONE;
                else                           state_nxt = S_ITER;
            end
            S_ITER: begin
                if (bus.abort)       state_nxt = S_IDLE;
                else if (cnt == '0)  state_nxt = S_FIXUP;
            end
            S_FIXUP: state_nxt = bus.abort ? S_IDLE : S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---- shared adder and shift network ----
    always_comb begin
        add_l = acc;
        add_r = '0;
        if (op_r) begin
            if (state == S_FIXUP) begin
                // restore a negative final remainder
                add_r = acc[ACC_W-1] ? m : '0;
            end else begin
                add_l = {acc[ACC_W-2:0], q[WORD-1]};
                add_r = acc[ACC_W-1] ? m : -m;
            end
        end else begin
`ifdef MULDIV_RADIX4_EN
            add_r = booth_addend({q[1], q[0], q_1}, m);
`else
            add_r = booth_addend({q[0], q_1}, m);
`endif
        end
        sum = add_l + add_r;

        if (op_r) begin
            acc_step = sum;
            q_step   = {q[WORD-2:0], ~sum[ACC_W-1]};
            q1_step  = q_1;
            res_hi   = cond_neg(sum[WORD-1:0], neg_r);
            res_lo   = cond_neg(q, neg_q);
        end else begin
`ifdef MULDIV_RADIX4_EN
            acc_step = sum >>> 2;
            q_step   = {sum[1:0], q[WORD-1:2]};
            q1_step  = q[1];
`else
            acc_step = sum >>> 1;
            q_step   = {sum[0], q[WORD-1:1]};
            q1_step  = q[0];
`endif
            res_hi   = acc[WORD-1:0];
            res_lo   = q;
        end
    end

    // ---- control and result registers ----
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= S_IDLE;
            cnt   <= '0;
            hi_r  <= '0;
            lo_r  <= '0;
            dbz_r <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_INIT)
                cnt <= op_r ? CNT_W'(WORD - 1) : CNT_W'(MUL_STEPS - 1);
            else if (state == S_ITER)
                cnt <= cnt - 1'b1;
            if (state_nxt == S_DONE) begin
                if (state == S_INIT) begin
                    hi_r  <= a_r;
                    lo_r  <= '1;
                    dbz_r <= 1'b1;
                end else begin
                    hi_r  <= res_hi;
                    lo_r  <= res_lo;
                    dbz_r <= 1'b0;
                end
            end
        end
    end

    // ---- datapath registers ----
    always_ff @(posedge clk) begin
        if (state == S_IDLE && bus.start_valid) begin
            op_r <= bus.op;
            a_r  <= bus.src_a;
            b_r  <= bus.src_b;
        end
        if (state == S_INIT) begin
            q_1 <= 1'b0;
            if (op_r) begin
                acc   <= '0;
                m     <= {{(ACC_W-WORD){1'b0}}, mag(b_r)};
                q     <= mag(a_r);
                neg_q <= a_r[WORD-1] ^ b_r[WORD-1];
                neg_r <= a_r[WORD-1];
            end else begin
                acc <= '0;
                m   <= {{(ACC_W-WORD){a_r[WORD-1]}}, a_r};
                q   <= b_r;
            end
        end else if (state == S_ITER) begin
            acc <= acc_step;
            q   <= q_step;
            q_1 <= q1_step;
        end
    end

    assign bus.start_ready = (state == S_IDLE);
    assign bus.busy        = (state != S_IDLE);
    assign bus.done        = (state == S_DONE);
    assign bus.hi_out      = hi_r;
    assign bus.lo_out      = lo_r;
    assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
    localparam int W = 32;
`ifdef MULDIV_RADIX4_EN
    localparam int MUL_LAT = W / 2 + 2;
`else
    localparam int MUL_LAT = W + 2;
`endif
    localparam int DIV_LAT = W + 2;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    muldiv_sequencer_if #(.WORD(W)) bus ();
    muldiv_sequencer #(.WORD(W)) dut (.clk(clk), .clr(clr), .bus(bus));

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input bit o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa, sbv, p, qq, rr;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        if (!o) begin
            p     = sa * sbv;
            e.hi  = p[63:32];
            e.lo  = p[31:0];
            e.dbz = 1'b0;
            e.lat = MUL_LAT;
        end else if (b == '0) begin
            e.hi  = a;
            e.lo  = '1;
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
            qq    = sa / sbv;
            rr    = sa % sbv;
            e.hi  = rr[31:0];
            e.lo  = qq[31:0];
            e.dbz = 1'b0;
            e.lat = DIV_LAT;
        end
        return e;
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!bus.start_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check({tag, ".ready"}, bus.start_ready, 1);
    endtask

    // issue one op with the given expectation, wait for done, compare
    task automatic do_op(input string tag, input bit o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input exp_t e);
        exp_t got;
        int   n;
        wait_ready(tag);
        sb.push_back(e);
        bus.op = o; bus.src_a = a; bus.src_b = b; bus.start_valid = 1'b1;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!bus.done && n < 200);
        got = sb.pop_front();
        check({tag, ".done"}, bus.done, 1);
        check({tag, ".lat"}, n, got.lat);
        check({tag, ".hi"}, bus.hi_out, got.hi);
        check({tag, ".lo"}, bus.lo_out, got.lo);
        check({tag, ".dbz"}, bus.div_by_zero, got.dbz);
        last_hi = got.hi;
        last_lo = got.lo;
        @(posedge clk); #1;
        check({tag, ".pulse"}, bus.done, 0);
    endtask

    task automatic do_model(input string tag, input bit o, input logic [W-1:0] a,
                            input logic [W-1:0] b);
        do_op(tag, o, a, b, model(o, a, b));
    endtask

    function automatic exp_t mk(input logic [W-1:0] hi, input logic [W-1:0] lo,
                                input logic dbz, input int lat);
        exp_t e;
        e.hi = hi; e.lo = lo; e.dbz = dbz; e.lat = lat;
        return e;
    endfunction

    initial begin
        exp_t got;
        int   dones, c1, c2, nbad;
        bit   ready_bad, drop_next;
        logic [W-1:0] ra, rb;

        bus.start_valid = 1'b0; bus.op = 1'b0; bus.src_a = '0; bus.src_b = '0; bus.abort = 1'b0;

        // reset
        #2 clr = 1'b0;
        #20;
        check("rst.hi", bus.hi_out, 0);
        check("rst.lo", bus.lo_out, 0);
        check("rst.done", bus.done, 0);
        check("rst.dbz", bus.div_by_zero, 0);
        check("rst.busy", bus.busy, 0);
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1;
        check("rst.ready", bus.start_ready, 1);

        // directed multiply / divide cases
        do_op("mul_7x-3", 1'b0, 32'd7, 32'hFFFFFFFD, mk(32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, MUL_LAT));
        do_op("mul_min2", 1'b0, 32'h80000000, 32'h80000000, mk(32'h40000000, 32'h0, 1'b0, MUL_LAT));
        do_op("mul_minx1", 1'b0, 32'h80000000, 32'd1, mk(32'hFFFFFFFF, 32'h80000000, 1'b0, MUL_LAT));
        do_op("div_-7/2", 1'b1, 32'hFFFFFFF9, 32'd2, mk(32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, DIV_LAT));
        do_op("div_min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, mk(32'h0, 32'h80000000, 1'b0, DIV_LAT));
        do_op("div_5/0", 1'b1, 32'd5, 32'd0, mk(32'd5, 32'hFFFFFFFF, 1'b1, 1));
        do_op("div_9/3", 1'b1, 32'd9, 32'd3, mk(32'd0, 32'd3, 1'b0, DIV_LAT));

        // mixed operands against the arithmetic model
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 40));
            if (i == 5) rb = -rb;
            do_model($sformatf("rnd%0d", i), 1'(i / 2 % 2), ra, rb);
        end

        // back-to-back with start_valid held high
        wait_ready("b2b");
        sb.push_back(model(1'b0, 32'h12345678, 32'hFEDCBA98));
        bus.op = 1'b0; bus.src_a = 32'h12345678; bus.src_b = 32'hFEDCBA98; bus.start_valid = 1'b1;
        @(posedge clk); #1;
        sb.push_back(model(1'b0, 32'hDEADBEEF, 32'h00000123));
        bus.src_a = 32'hDEADBEEF; bus.src_b = 32'h00000123;
        dones = 0; c1 = 0; c2 = 0; ready_bad = 1'b0; drop_next = 1'b0;
        for (int c = 1; c <= 3 * MUL_LAT + 10; c++) begin
            @(posedge clk); #1;
            if (drop_next) begin bus.start_valid = 1'b0; drop_next = 1'b0; end
            if (bus.busy && bus.start_ready) ready_bad = 1'b1;
            if (bus.done) begin
                dones++;
                if (dones == 1) c1 = c; else if (dones == 2) c2 = c;
                if (sb.size() > 0) begin
                    got = sb.pop_front();
                    check($sformatf("b2b%0d.hi", dones), bus.hi_out, got.hi);
                    check($sformatf("b2b%0d.lo", dones), bus.lo_out, got.lo);
                    last_hi = got.hi; last_lo = got.lo;
                end
            end
            if (bus.start_ready && bus.start_valid) drop_next = 1'b1;
        end
        check("b2b.ready_low_busy", ready_bad, 0);
        check("b2b.dones", dones, 2);
        check("b2b.first_lat", c1, MUL_LAT);
        check("b2b.gap", c2 - c1, MUL_LAT + 2);
        check("b2b.sb_empty", sb.size(), 0);

        // abort during ITER step 10
        wait_ready("abort");
        bus.op = 1'b0; bus.src_a = 32'h00001234; bus.src_b = 32'h00005678; bus.start_valid = 1'b1;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        check("abort.busy_before", bus.busy, 1);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check("abort.busy", bus.busy, 0);
        check("abort.ready", bus.start_ready, 1);
        check("abort.hi", bus.hi_out, last_hi);
        check("abort.lo", bus.lo_out, last_lo);
        nbad = 0;
        for (int c = 0; c < MUL_LAT + 10; c++) begin
            @(posedge clk); #1;
            if (bus.done) nbad++;
        end
        check("abort.no_done", nbad, 0);

        // clr pulse mid-multiply
        wait_ready("clr");
        bus.op = 1'b0; bus.src_a = 32'h0000_0FFF; bus.src_b = 32'h0000_0FFF; bus.start_valid = 1'b1;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        clr = 1'b0;
        #1;
        check("clr.hi", bus.hi_out, 0);
        check("clr.lo", bus.lo_out, 0);
        check("clr.done", bus.done, 0);
        check("clr.dbz", bus.div_by_zero, 0);
        check("clr.busy", bus.busy, 0);
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1;
        check("clr.ready", bus.start_ready, 1);
        do_model("after_clr", 1'b1, 32'hFFFFFF9C, 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
